beep_gen: RTL and testbench



---
 rtl/beep_pkg.sv | 12 +
 rtl/beep_gen_tone_div.sv | 45 ++++
 rtl/beep_gen.sv | 135 +++++++++++++
 tb/tb_beep_gen.sv | 291 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/beep_pkg.sv
// Shared types and constants for the beep_gen buzzer/LED burst driver.
package beep_pkg;

   localparam int BURST_W = 4;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_ON   = 2'd1,
      ST_OFF  = 2'd2
   } state_t;

endpackage

// File: rtl/beep_gen_tone_div.sv
// Tone carrier divider: level starts high on clear and toggles every TONE_HALF enabled cycles.
// level_d_o is the next-cycle level so the parent can register it straight into its output flop.
module tone_div #(
   parameter int TONE_HALF = 2,
   parameter int CNT_W     = 16
) (
   input  logic clk,
   input  logic rst_n,
   input  logic en_i,
   input  logic clr_i,
   output logic level_d_o
);

   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             lvl_q, lvl_d;

   always_comb begin
      cnt_d = cnt_q;
      lvl_d = lvl_q;
      if (clr_i) begin
         cnt_d = '0;
         lvl_d = 1'b1;
      end else if (en_i) begin
         if (cnt_q == CNT_W'(TONE_HALF - 1)) begin
            cnt_d = '0;
            lvl_d = ~lvl_q;
         end else begin
            cnt_d = cnt_q + 1'b1;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q <= '0;
         lvl_q <= 1'b0;
      end else begin
         cnt_q <= cnt_d;
         lvl_q <= lvl_d;
      end
   end

   assign level_d_o = lvl_d;

endmodule

// File: rtl/beep_gen.sv
// Event-to-waveform driver: a start pulse yields `count` ON bursts separated by OFF gaps.
// Optional macro BEEP_TONE_EN replaces the steady ON level with a square-wave tone carrier.
module beep_gen
   import beep_pkg::*;
#(
   parameter int ON_CYCLES  = 4,
   parameter int OFF_CYCLES = 2,
   parameter int CNT_W      = 16,
   parameter int TONE_HALF  = 2
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               start,
   input  logic [BURST_W-1:0] count,
   input  logic               stop,
   output logic               out,
   output logic               busy,
   output logic               done
);

   if (ON_CYCLES < 1 || OFF_CYCLES < 1 || TONE_HALF < 1 || CNT_W < 1 ||
       ON_CYCLES > 2**CNT_W || OFF_CYCLES > 2**CNT_W) begin : g_bad_params
      $error("beep_gen: illegal parameter combination");
   end

   state_t             state_q, state_d;
   logic [CNT_W-1:0]   phase_q, phase_d;
   logic [BURST_W-1:0] rem_q, rem_d;
   logic               out_q, out_d;
   logic               busy_q, busy_d;
   logic               done_q, done_d;
   logic               on_d;

   always_comb begin
      state_d = state_q;
      phase_d = phase_q;
      rem_d   = rem_q;
      done_d  = 1'b0;
      case (state_q)
         ST_IDLE: begin
            // stop has priority over a simultaneous start
            if (start && (count != '0) && !stop) begin
               state_d = ST_ON;
               phase_d = CNT_W'(ON_CYCLES - 1);
               rem_d   = count;
            end
         end
         ST_ON: begin
            if (stop) begin
               state_d = ST_IDLE;
               phase_d = '0;
               rem_d   = '0;
            end else if (phase_q == '0) begin
               if (rem_q > BURST_W'(1)) begin
                  state_d = ST_OFF;
                  phase_d = CNT_W'(OFF_CYCLES - 1);
                  rem_d   = rem_q - 1'b1;
               end else begin
                  state_d = ST_IDLE;
                  rem_d   = '0;
                  done_d  = 1'b1;
               end
            end else begin
               phase_d = phase_q - 1'b1;
            end
         end
         ST_OFF: begin
            if (stop) begin
               state_d = ST_IDLE;
               phase_d = '0;
               rem_d   = '0;
            end else if (phase_q == '0) begin
               state_d = ST_ON;
               phase_d = CNT_W'(ON_CYCLES - 1);
            end else begin
               phase_d = phase_q - 1'b1;
            end
         end
         default: begin
            state_d = ST_IDLE;
            phase_d = '0;
            rem_d   = '0;
         end
      endcase
   end

   assign on_d   = (state_d == ST_ON);
   assign busy_d = (state_d != ST_IDLE);

`ifdef BEEP_TONE_EN
   logic on_entry;
   logic tone_level_d;

   // carrier restarts high on every entry into ON
   assign on_entry = on_d && (state_q != ST_ON);

   tone_div #(
      .TONE_HALF (TONE_HALF),
      .CNT_W     (CNT_W)
   ) u_tone (
      .clk       (clk),
      .rst_n     (rst_n),
      .en_i      (on_d),
      .clr_i     (on_entry),
      .level_d_o (tone_level_d)
   );

   assign out_d = on_d & tone_level_d;
`else
   assign out_d = on_d;
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ST_IDLE;
         phase_q <= '0;
         rem_q   <= '0;
         out_q   <= 1'b0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         phase_q <= phase_d;
         rem_q   <= rem_d;
         out_q   <= out_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
      end
   end

   assign out  = out_q;
   assign busy = busy_q;
   assign done = done_q;

endmodule

// File: tb/tb_beep_gen.sv
// Self-checking bench for beep_gen: directed scenarios plus random traffic against a timeline model.
module tb_beep_gen;

   localparam int ON  = 4;
   localparam int OFF = 2;
   localparam int TH  = 2;
   localparam int CW  = 16;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       start = 1'b0;
   logic       stop = 1'b0;
   logic [3:0] count = 4'd0;
   logic       out, busy, done;

   always #5 clk = ~clk;

   beep_gen #(
      .ON_CYCLES  (ON),
      .OFF_CYCLES (OFF),
      .CNT_W      (CW),
      .TONE_HALF  (TH)
   ) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .start (start),
      .count (count),
      .stop  (stop),
      .out   (out),
      .busy  (busy),
      .done  (done)
   );

   int checks = 0;
   int errors = 0;

   // Model: an accepted request at edge a occupies the m_len intervals after edges a..a+m_len-1,
   // and done appears in the interval after edge a+m_len.
   int   edge_no = 0;
   bit   m_active = 1'b0;
   int   m_a = 0;
   int   m_len = 0;
   logic exp_out = 1'b0, exp_busy = 1'b0, exp_done = 1'b0;

   function automatic int seq_len(input int n);
      return n * ON + (n - 1) * OFF;
   endfunction

   function automatic logic wave(input int rel);
      int  ph;
      logic lvl;
      ph  = rel % (ON + OFF);
      lvl = (ph < ON);
`ifdef BEEP_TONE_EN
      lvl = lvl && (((ph / TH) % 2) == 0);
`endif
      return lvl;
   endfunction

   task automatic tick(input logic st, input logic [3:0] cn, input logic sp);
      int  e;
      int  rel;
      bit  busy_prev;
      @(negedge clk);
      start = st;
      count = cn;
      stop  = sp;
      @(posedge clk);
      e = edge_no;
      edge_no++;
      busy_prev = m_active && ((e - 1 - m_a) < m_len);
      if (busy_prev && sp) begin
         m_active = 1'b0;
         $display("edge %0d: stop aborts sequence", e);
      end else if (!busy_prev && st && (cn != 4'd0) && !sp) begin
         m_active = 1'b1;
         m_a      = e;
         m_len    = seq_len(int'(cn));
         $display("edge %0d: start accepted count=%0d len=%0d", e, cn, m_len);
      end
      if (m_active) begin
         rel      = e - m_a;
         exp_busy = (rel < m_len);
         exp_done = (rel == m_len);
         exp_out  = exp_busy && wave(rel);
      end else begin
         exp_busy = 1'b0;
         exp_done = 1'b0;
         exp_out  = 1'b0;
      end
      #1;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      if (out !== 1'b0) begin errors++; $display("FAIL reset_out got %b want 0", out); end
      checks++;
      if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", busy); end
      checks++;
      if (done !== 1'b0) begin errors++; $display("FAIL reset_done got %b want 0", done); end
      checks++;
      @(negedge clk);
      rst_n = 1'b1;
      m_active = 1'b0;
   endtask

   task automatic test_count3();
      int busy_cnt = 0, done_cnt = 0, done_at = 0;
      for (int c = 1; c <= 20; c++) begin
         tick(c == 1, 4'd3, 1'b0);
         if (out !== exp_out || busy !== exp_busy || done !== exp_done) begin
            errors++;
            $display("FAIL count3 cycle %0d out/busy/done got %b%b%b want %b%b%b",
                     c, out, busy, done, exp_out, exp_busy, exp_done);
         end
         checks++;
         if (busy === 1'b1) busy_cnt++;
         if (done === 1'b1) begin done_cnt++; done_at = c; end
      end
      if (busy_cnt != 16 || done_cnt != 1 || done_at != 17) begin
         errors++;
         $display("FAIL count3_totals busy=%0d done=%0d done_at=%0d want 16 1 17",
                  busy_cnt, done_cnt, done_at);
      end
      checks++;
   endtask

   task automatic test_count1();
      for (int c = 1; c <= 8; c++) begin
         tick(c == 1, 4'd1, 1'b0);
         if (out !== exp_out || busy !== exp_busy || done !== exp_done) begin
            errors++;
            $display("FAIL count1 cycle %0d out/busy/done got %b%b%b want %b%b%b",
                     c, out, busy, done, exp_out, exp_busy, exp_done);
         end
         checks++;
      end
   endtask

   task automatic test_count0();
      for (int c = 1; c <= 6; c++) begin
         tick(c == 1, 4'd0, 1'b0);
         if (out !== 1'b0 || busy !== 1'b0 || done !== 1'b0) begin
            errors++;
            $display("FAIL count0 cycle %0d out/busy/done got %b%b%b want 000",
                     c, out, busy, done);
         end
         checks++;
      end
   endtask

   task automatic test_ignore_start();
      for (int c = 1; c <= 20; c++) begin
         tick(c == 1 || c == 6, (c == 6) ? 4'($urandom_range(1, 15)) : 4'd3, 1'b0);
         if (out !== exp_out || busy !== exp_busy || done !== exp_done) begin
            errors++;
            $display("FAIL ignore_start cycle %0d out/busy/done got %b%b%b want %b%b%b",
                     c, out, busy, done, exp_out, exp_busy, exp_done);
         end
         checks++;
      end
   endtask

   task automatic test_stop();
      int done_cnt = 0;
      for (int c = 1; c <= 20; c++) begin
         tick(c == 1, 4'd3, c == 9);
         if (out !== exp_out || busy !== exp_busy || done !== exp_done) begin
            errors++;
            $display("FAIL stop cycle %0d out/busy/done got %b%b%b want %b%b%b",
                     c, out, busy, done, exp_out, exp_busy, exp_done);
         end
         checks++;
         if (c == 9 && (out !== 1'b0 || busy !== 1'b0)) begin
            errors++;
            $display("FAIL stop_cycle9 out/busy got %b%b want 00", out, busy);
         end
         if (c == 9) checks++;
         if (done === 1'b1) done_cnt++;
      end
      if (done_cnt != 0) begin
         errors++;
         $display("FAIL stop_no_done got %0d done pulses want 0", done_cnt);
      end
      checks++;
   endtask

   task automatic test_stop_start_idle();
      for (int c = 1; c <= 4; c++) begin
         tick(c == 1, 4'd5, c == 1);
         if (out !== 1'b0 || busy !== 1'b0 || done !== 1'b0) begin
            errors++;
            $display("FAIL stop_start_idle cycle %0d out/busy/done got %b%b%b want 000",
                     c, out, busy, done);
         end
         checks++;
      end
   endtask

   task automatic test_back_to_back();
      bit seen_done = 1'b0;
      tick(1'b1, 4'd1, 1'b0);
      for (int c = 0; c < 20 && !seen_done; c++) begin
         tick(1'b0, 4'd0, 1'b0);
         if (done === 1'b1) seen_done = 1'b1;
      end
      if (!seen_done) begin
         errors++;
         $display("FAIL b2b_done_timeout got no done within 20 cycles want done");
      end
      checks++;
      tick(1'b1, 4'd2, 1'b0);
      if (busy !== 1'b1 || out !== 1'b1 || busy !== exp_busy) begin
         errors++;
         $display("FAIL b2b_restart busy/out got %b%b want 11", busy, out);
      end
      checks++;
      for (int c = 0; c < 16; c++) begin
         tick(1'b0, 4'd0, 1'b0);
         if (out !== exp_out || busy !== exp_busy || done !== exp_done) begin
            errors++;
            $display("FAIL b2b cycle %0d out/busy/done got %b%b%b want %b%b%b",
                     c, out, busy, done, exp_out, exp_busy, exp_done);
         end
         checks++;
      end
   endtask

   task automatic test_async_reset();
      tick(1'b1, 4'd3, 1'b0);
      tick(1'b0, 4'd0, 1'b0);
      tick(1'b0, 4'd0, 1'b0);
      #2;
      rst_n = 1'b0;
      m_active = 1'b0;
      #1;
      if (out !== 1'b0 || busy !== 1'b0 || done !== 1'b0) begin
         errors++;
         $display("FAIL async_reset out/busy/done got %b%b%b want 000", out, busy, done);
      end
      checks++;
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      for (int c = 1; c <= 20; c++) begin
         tick(c == 1, 4'd3, 1'b0);
         if (out !== exp_out || busy !== exp_busy || done !== exp_done) begin
            errors++;
            $display("FAIL after_reset cycle %0d out/busy/done got %b%b%b want %b%b%b",
                     c, out, busy, done, exp_out, exp_busy, exp_done);
         end
         checks++;
      end
   endtask

   task automatic test_random();
      for (int c = 0; c < 800; c++) begin
         tick($urandom_range(0, 5) == 0, 4'($urandom_range(0, 15)), $urandom_range(0, 39) == 0);
         if (out !== exp_out || busy !== exp_busy || done !== exp_done) begin
            errors++;
            $display("FAIL random cycle %0d out/busy/done got %b%b%b want %b%b%b",
                     c, out, busy, done, exp_out, exp_busy, exp_done);
         end
         checks++;
      end
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      test_reset();
      test_count3();
      test_count1();
      test_count0();
      test_ignore_start();
      test_stop();
      test_stop_start_idle();
      test_back_to_back();
      test_async_reset();
      test_random();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
